// File: rtl/trap_ctrl.sv
// Interrupt/exception sequencer: edge-captured maskable IRQs, illegal-op traps, EPC/cause, kernel mode.
// Latency: pc_src/trap_vector are combinational this cycle; epc/cause/state/pending update next cycle.
// Backpressure: none; decisions are taken only on cycles with instr_valid, otherwise state holds.
module trap_ctrl #(
  parameter int unsigned N_IRQ   = 4,
  parameter int unsigned PC_W    = 32,
  parameter logic [31:0] VEC_IRQ = 32'h80000004,
  parameter logic [31:0] VEC_EXC = 32'h80000008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ack_we,
  input  logic [3:0]       ack_idx,
  input  logic             instr_valid,
  input  logic             illegal_op,
  input  logic             eret,
  input  logic [PC_W-1:0]  pc_cur,
  input  logic [PC_W-1:0]  pc_plus4,
  output logic [2:0]       pc_src,
  output logic [PC_W-1:0]  trap_vector,
  output logic [PC_W-1:0]  epc,
  output logic [7:0]       cause,
  output logic             kernel_mode,
  output logic [N_IRQ-1:0] irq_pending
);

  typedef enum logic {
    USER   = 1'b0,
    KERNEL = 1'b1
  } state_t;

  localparam logic [2:0] SRC_NONE = 3'b000;
  localparam logic [2:0] SRC_IRQ  = 3'b100;
  localparam logic [2:0] SRC_EXC  = 3'b101;
  localparam logic [2:0] SRC_ERET = 3'b110;

  localparam logic [PC_W-1:0] VEC_IRQ_PC = PC_W'(VEC_IRQ);
  localparam logic [PC_W-1:0] VEC_EXC_PC = PC_W'(VEC_EXC);

  state_t           state;
  state_t           state_nxt;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] pending_nxt;
  logic [N_IRQ-1:0] irq_mask;
  logic [3:0]       irq_k;

  // Decision strobes, one-hot by construction of the priority chain
  logic take_exc;    // illegal op in USER
  logic take_irq;    // enabled IRQ pending in USER
  logic dbl_fault;   // illegal op in KERNEL
  logic do_eret;     // return from handler

  assign irq_pending = pending & irq_mask;
  assign kernel_mode = (state == KERNEL);

  // Pending update: ack clears one in-range bit, a fresh rising edge sets it and wins over the ack
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (ack_we && (ack_idx == 4'(i))) pending_nxt[i] = 1'b0;
    end
    pending_nxt = pending_nxt | (irq_in & ~irq_prev);
  end

  // Lowest-numbered enabled pending line has highest priority
  always_comb begin
    irq_k = 4'd0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (irq_pending[i]) irq_k = 4'(i);
    end
  end

  // Edge detector, pending latch and mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
      irq_mask <= '0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_nxt;
      if (mask_we) irq_mask <= mask_wdata;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= USER;
    else       state <= state_nxt;
  end

  // FSM next-state: enter KERNEL on any USER trap, leave only on eret
  always_comb begin
    state_nxt = state;
    if (take_exc || take_irq) state_nxt = KERNEL;
    else if (do_eret)         state_nxt = USER;
  end

  // FSM outputs: trap decision and PC override; forced quiet while reset is held
  always_comb begin
    take_exc    = 1'b0;
    take_irq    = 1'b0;
    dbl_fault   = 1'b0;
    do_eret     = 1'b0;
    pc_src      = SRC_NONE;
    trap_vector = '0;
    if (!reset && instr_valid) begin
      case (state)
        USER: begin
          if (illegal_op) begin
            take_exc    = 1'b1;
            pc_src      = SRC_EXC;
            trap_vector = VEC_EXC_PC;
          end else if (|irq_pending) begin
            take_irq    = 1'b1;
            pc_src      = SRC_IRQ;
            trap_vector = VEC_IRQ_PC;
          end
          // eret in USER mode is a no-op
        end
        KERNEL: begin
          // IRQs stay pending while a handler runs
          if (illegal_op) begin
            dbl_fault   = 1'b1;
            pc_src      = SRC_EXC;
            trap_vector = VEC_EXC_PC;
          end else if (eret) begin
            do_eret     = 1'b1;
            pc_src      = SRC_ERET;
            trap_vector = epc;
          end
        end
        default: begin
          pc_src = SRC_NONE;
        end
      endcase
    end
  end

  // Trap bookkeeping: EPC and cause; a double fault only rewrites cause so the original EPC survives
  always_ff @(posedge clk) begin
    if (reset) begin
      epc   <= '0;
      cause <= 8'h00;
    end else if (take_exc) begin
      epc   <= pc_cur;
      cause <= 8'h00;
    end else if (take_irq) begin
      epc   <= pc_plus4;
      cause <= 8'h10 + {4'b0000, irq_k};
    end else if (dbl_fault) begin
      cause <= 8'h01;
    end
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Parametrised interrupt/exception sequencer; successor to the combinational IRQ/exception override in the control decoder.
- Handles N_IRQ edge-captured, maskable, prioritised interrupt lines and illegal-instruction exceptions.
- Tracks kernel mode, saves EPC and cause, and drives the PC-source override consumed by the PC mux.
- Sits between the decoder (illegal_op, eret) and the PC/next-PC logic of the single-cycle datapath.

Parameters:
N_IRQ, 4, number of interrupt lines (1..16)
PC_W, 32, program-counter width
VEC_IRQ, 32'h80000004, interrupt handler address (low PC_W bits used)
VEC_EXC, 32'h80000008, exception handler address

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq_in  in  N_IRQ  level interrupt requests from peripherals, same clock domain
mask_we  in  1  write irq_mask
mask_wdata  in  N_IRQ  new mask (1 = enabled)
ack_we  in  1  clear one pending bit
ack_idx  in  4  index of pending bit to clear
instr_valid  in  1  an instruction completes this cycle
illegal_op  in  1  decoder flags current instruction undefined
eret  in  1  current instruction is return-from-trap
pc_cur  in  PC_W  PC of current instruction
pc_plus4  in  PC_W  PC of next sequential instruction
pc_src  out  3  override: 3'b000 none, 3'b100 IRQ, 3'b101 exception, 3'b110 eret
trap_vector  out  PC_W  target address when pc_src != 0 (EPC for eret)
epc  out  PC_W  saved return address
cause  out  8  last trap cause
kernel_mode  out  1  1 while inside a handler
irq_pending  out  N_IRQ  pending & mask

Behaviour:
- Reset: irq_mask=0, pending=0, irq_prev=0, epc=0, cause=0, kernel_mode=0, state=USER. pc_src=0 while reset is high.
- Edge capture:
  - irq_prev <= irq_in every cycle.
  - pending[i] set when irq_in[i] & ~irq_prev[i].
  - pending[i] cleared by ack_we with ack_idx==i; ack_idx >= N_IRQ is ignored.
  - Set and clear on the same bit in the same cycle: set wins.
- Mask: irq_mask <= mask_wdata on mask_we; takes effect the next cycle. irq_pending = pending & irq_mask.
- FSM states are USER and KERNEL. kernel_mode = (state==KERNEL).
- All decisions below apply only when instr_valid=1. With instr_valid=0: pc_src=0 and no state change except pending/mask/irq_prev.
- USER, priority order:
  - illegal_op: pc_src=101, trap_vector=VEC_EXC. Next cycle: epc=pc_cur, cause=8'h00, state=KERNEL.
  - else irq_pending!=0: k = lowest set index. pc_src=100, trap_vector=VEC_IRQ. Next cycle: epc=pc_plus4, cause=8'h10+k, state=KERNEL. pending[k] is not auto-cleared; software acks it.
  - else eret: ignored, pc_src=0.
- KERNEL:
  - IRQs are not taken; they remain pending.
  - illegal_op: pc_src=101, trap_vector=VEC_EXC, cause=8'h01 (double fault). epc unchanged; state stays KERNEL.
  - else eret: pc_src=110, trap_vector=epc, state=USER next cycle.
- illegal_op and eret together: illegal_op wins.
- pc_src and trap_vector are combinational from the current state and inputs. epc, cause, state, pending and mask are registered.
- An IRQ edge arriving in the same cycle as a USER instruction is taken no earlier than the next valid instruction, because pending is registered.
- Reset mid-handler: returns to USER with all state cleared; no eret is required.
- Widths: trap_vector and epc are PC_W. Cause index k fits in 4 bits; 8'h10+k has no overflow for N_IRQ ≤ 16.

Test Plan:
- Reset, then irq_in[2] rises, mask=4'b0100, instr_valid=1 with pc_cur=0x100, pc_plus4=0x104 -> the following instruction cycle gives pc_src=100 and trap_vector=0x80000004; next cycle epc=0x104, cause=0x12, kernel_mode=1.
- Edges on irq_in[1] and irq_in[3] in the same cycle, both enabled -> cause=0x11 taken first. After ack_idx=1 and eret, the next user instruction takes IRQ 3 (cause=0x13).
- illegal_op with pc_cur=0x200 in USER -> pc_src=101, epc=0x200, cause=0x00. A second illegal_op in KERNEL -> pc_src=101, cause=0x01, epc still 0x200.
- In KERNEL, irq_in[0] edge with mask=1 -> no trap; irq_pending[0]=1. eret -> pc_src=110, trap_vector=epc, kernel_mode=0. Next valid instruction takes IRQ 0.
- Masked edge (mask=0): pending sets, irq_pending=0, no trap. Writing mask=1 -> trap on the next valid instruction. Same-cycle ack and new edge on one bit -> bit stays 1.
- Reset asserted while in KERNEL with pending=4'b1111 -> all registers 0 and pc_src=0 next cycle; instr_valid with no IRQs gives no trap.
